baud_tick_gen: RTL and testbench

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

---
 rtl/baud_pkg.sv | 26 ++
 rtl/baud_down_ctr.sv | 37 +++
 rtl/baud_tick_gen.sv | 130 +++++++++++++
 tb/tb_baud_tick_gen.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared constants for the baud tick generator: register addresses, standard
// divisors for a 100 MHz clock with 16x oversampling, and the phase-width helper.
package baud_pkg;

    localparam logic [1:0] ADDR_DIV_LO = 2'h2;
    localparam logic [1:0] ADDR_DIV_HI = 2'h3;

    localparam int unsigned DIV_W_MIN = 9;
    localparam int unsigned DIV_W_MAX = 16;

    // Period is div+1 cycles, so each value is round(100e6 / (baud * 16)) - 1.
    localparam logic [15:0] DIV_9600_100M  = 16'd650;
    localparam logic [15:0] DIV_19200_100M = 16'd325;
    localparam logic [15:0] DIV_38400_100M = 16'd162;
    localparam logic [15:0] DIV_57600_100M = 16'd108;

    function automatic int unsigned ph_width(input int unsigned ovs);
        int unsigned w;
        w = 1;
        if (ovs > 1) begin
            w = $unsigned($clog2(ovs));
        end
        return w;
    endfunction

endpackage

// File: rtl/baud_down_ctr.sv
// Reloadable down-counter: counts down on en, reloads load_val after reaching zero
// or immediately on load; term flags the zero count.
module baud_down_ctr #(
    parameter int unsigned   W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         term
);
    logic [W-1:0] count_q, count_d;

    assign term  = (count_q == '0);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = term ? load_val : (count_q - W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable baud tick generator: byte-wide divisor writes, oversample and bit ticks.
// Define BAUD_TICK_RXSYNC_EN to add the rx_sync start-bit resync input and rx_mid strobe.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned OVS         = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd162
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [1:0]       ioaddr,
    input  logic [7:0]       divisor,
`ifdef BAUD_TICK_RXSYNC_EN
    input  logic             rx_sync,
    output logic             rx_mid,
`endif
    output logic             rx_tick,
    output logic             tx_tick,
    output logic [DIV_W-1:0] div_active
);
    localparam int unsigned      PH_W    = ph_width(OVS);
    localparam logic [DIV_W-1:0] RST_DIV = DEFAULT_DIV[DIV_W-1:0];
    localparam logic [PH_W-1:0]  PH_TOP  = PH_W'(OVS - 1);

    logic [DIV_W-1:0] div_active_q, div_active_d;
    logic [7:0]       shadow_q, shadow_d;
    logic             rx_tick_q, rx_tick_d;
    logic             tx_tick_q, tx_tick_d;
    logic [15:0]      div_wide;
    logic             commit;
    logic             sync;
    logic             cnt_load;
    logic             cnt_term;
    logic             ph_term;
    logic             rx_evt;
    logic [DIV_W-1:0] cnt_val;
    logic [PH_W-1:0]  ph_val;

    assign div_wide = {divisor, shadow_q};

    always_comb begin
        shadow_d     = shadow_q;
        div_active_d = div_active_q;
        commit       = 1'b0;
        if (wr && (ioaddr == ADDR_DIV_LO)) begin
            shadow_d = divisor;
        end
        if (wr && (ioaddr == ADDR_DIV_HI)) begin
            commit       = 1'b1;
            div_active_d = div_wide[DIV_W-1:0];
        end
        // div_active_d already holds the new divisor on a commit, so one reload path serves both.
        cnt_load  = commit | sync;
        rx_evt    = cnt_term & ~sync;
        rx_tick_d = rx_evt;
        tx_tick_d = rx_evt & ph_term;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_active_q <= RST_DIV;
            shadow_q     <= DEFAULT_DIV[7:0];
            rx_tick_q    <= 1'b0;
            tx_tick_q    <= 1'b0;
        end else begin
            div_active_q <= div_active_d;
            shadow_q     <= shadow_d;
            rx_tick_q    <= rx_tick_d;
            tx_tick_q    <= tx_tick_d;
        end
    end

    baud_down_ctr #(
        .W       (DIV_W),
        .RST_VAL (RST_DIV)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (1'b1),
        .load_val (div_active_d),
        .count    (cnt_val),
        .term     (cnt_term)
    );

    // Phase counts down from OVS-1, so its zero marks the bit-rate wrap.
    baud_down_ctr #(
        .W       (PH_W),
        .RST_VAL (PH_TOP)
    ) u_ph (
        .clk      (clk),
        .rst      (rst),
        .load     (sync),
        .en       (rx_evt),
        .load_val (PH_TOP),
        .count    (ph_val),
        .term     (ph_term)
    );

`ifdef BAUD_TICK_RXSYNC_EN
    localparam logic [PH_W-1:0] PH_MID = PH_W'(OVS / 2);
    logic rx_mid_q, rx_mid_d;
    logic unused_sig;

    assign sync       = rx_sync;
    assign rx_mid_d   = rx_evt & (ph_val == PH_MID);
    assign rx_mid     = rx_mid_q;
    assign unused_sig = ^cnt_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_mid_q <= 1'b0;
        end else begin
            rx_mid_q <= rx_mid_d;
        end
    end
`else
    logic unused_sig;

    assign sync       = 1'b0;
    assign unused_sig = ^{cnt_val, ph_val};
`endif

    assign rx_tick    = rx_tick_q;
    assign tx_tick    = tx_tick_q;
    assign div_active = div_active_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen against an event-schedule reference model.
// Exercises the rx_sync/rx_mid path when BAUD_TICK_RXSYNC_EN is defined.
module tb_baud_tick_gen;

`ifdef BAUD_TICK_RXSYNC_EN
    localparam int T_OVS = 16;
    localparam int T_DEF = 1;
`else
    localparam int T_OVS = 4;
    localparam int T_DEF = 4;
`endif
    localparam int T_PER = T_DEF + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [1:0]  ioaddr;
    logic [7:0]  divisor;
    logic        rx_tick;
    logic        tx_tick;
    logic [15:0] div_active;
`ifdef BAUD_TICK_RXSYNC_EN
    logic        rx_sync;
    logic        rx_mid;
`endif

    int errors = 0;
    int checks = 0;
    bit verbose = 1'b1;

    // Reference model: absolute edge of the next scheduled tick plus a tick tally.
    longint      edge_n = 0;
    longint      m_next = 0;
    int          m_ticks = 0;
    logic [15:0] m_div;
    logic [7:0]  m_shadow;
    logic        exp_rx = 1'b0;
    logic        exp_tx = 1'b0;
    logic        exp_mid = 1'b0;

    always #5 clk = ~clk;

    baud_tick_gen #(
        .DIV_W       (16),
        .OVS         (T_OVS),
        .DEFAULT_DIV (16'(T_DEF))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr),
        .ioaddr     (ioaddr),
        .divisor    (divisor),
`ifdef BAUD_TICK_RXSYNC_EN
        .rx_sync    (rx_sync),
        .rx_mid     (rx_mid),
`endif
        .rx_tick    (rx_tick),
        .tx_tick    (tx_tick),
        .div_active (div_active)
    );

    // Drive one clock edge and advance the model; outputs are sampled 1 ns after the edge.
    task automatic step(input logic r, input logic w, input logic [1:0] a,
                        input logic [7:0] d, input logic s);
        logic fire;
        rst = r; wr = w; ioaddr = a; divisor = d;
`ifdef BAUD_TICK_RXSYNC_EN
        rx_sync = s;
`endif
        @(posedge clk);
        edge_n++;
        if (r) begin
            m_div    = 16'(T_DEF);
            m_shadow = 8'(T_DEF % 256);
            m_next   = edge_n + T_DEF + 1;
            m_ticks  = 0;
            exp_rx = 1'b0; exp_tx = 1'b0; exp_mid = 1'b0;
        end else begin
            fire = (edge_n == m_next);
            if (w && a == 2'h3) m_div = {d, m_shadow};
            if (w && a == 2'h2) m_shadow = d;
            exp_rx = 1'b0; exp_tx = 1'b0; exp_mid = 1'b0;
            if (s) begin
                m_next  = edge_n + longint'(m_div) + 1;
                m_ticks = 0;
            end else begin
                if ((w && a == 2'h3) || fire) m_next = edge_n + longint'(m_div) + 1;
                if (fire) begin
                    m_ticks++;
                    exp_rx  = 1'b1;
                    exp_tx  = ((m_ticks % T_OVS) == 0);
                    exp_mid = ((m_ticks % T_OVS) == T_OVS / 2);
                end
            end
        end
        #1;
        if (verbose && w && a[1])
            $display("write addr=%0d data=%02h rst=%b -> div_active=%04h", a, d, r, div_active);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 2'h0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 2'h0, 8'h00, 1'b0);
        checks++;
        if (rx_tick !== 1'b0 || tx_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_ticks rx=%b tx=%b expected 0 0", rx_tick, tx_tick);
        end
        checks++;
        if (div_active !== 16'(T_DEF)) begin
            errors++;
            $display("FAIL reset_div got=%04h expected=%04h", div_active, 16'(T_DEF));
        end
        $display("test_reset done");
    endtask

    task automatic test_default_period();
        int rx_q[$];
        int tx_q[$];
        int bad;
        for (int i = 1; i <= 3 * T_PER * T_OVS; i++) begin
            step(1'b0, 1'b0, 2'h0, 8'h00, 1'b0);
            checks++;
            if (rx_tick !== exp_rx || tx_tick !== exp_tx) begin
                errors++;
                $display("FAIL default_model edge=%0d rx=%b tx=%b expected rx=%b tx=%b",
                         i, rx_tick, tx_tick, exp_rx, exp_tx);
            end
            if (rx_tick) rx_q.push_back(i);
            if (tx_tick) tx_q.push_back(i);
        end
        checks++;
        if (rx_q.size() == 0 || rx_q[0] != T_PER) begin
            errors++;
            $display("FAIL first_rx edge=%0d expected=%0d", (rx_q.size() == 0) ? -1 : rx_q[0], T_PER);
        end
        bad = 0;
        for (int k = 1; k < rx_q.size(); k++) if (rx_q[k] - rx_q[k-1] != T_PER) bad++;
        checks++;
        if (bad != 0 || rx_q.size() != 3 * T_OVS) begin
            errors++;
            $display("FAIL rx_period bad_gaps=%0d count=%0d expected 0 gaps of %0d, count %0d",
                     bad, rx_q.size(), T_PER, 3 * T_OVS);
        end
        checks++;
        if (tx_q.size() != 3 || tx_q[0] != T_PER * T_OVS || tx_q[1] - tx_q[0] != T_PER * T_OVS) begin
            errors++;
            $display("FAIL tx_period count=%0d first=%0d expected count 3 every %0d",
                     tx_q.size(), (tx_q.size() == 0) ? -1 : tx_q[0], T_PER * T_OVS);
        end
        checks++;
        if (div_active !== 16'(T_DEF)) begin
            errors++;
            $display("FAIL default_div got=%04h expected=%04h", div_active, 16'(T_DEF));
        end
        $display("test_default_period done");
    endtask

    task automatic test_shadow_write();
        int rx_q[$];
        step(1'b0, 1'b1, 2'h2, 8'hAB, 1'b0);
        checks++;
        if (div_active !== 16'(T_DEF)) begin
            errors++;
            $display("FAIL lo_no_commit got=%04h expected=%04h", div_active, 16'(T_DEF));
        end
        step(1'b0, 1'b1, 2'h3, 8'h00, 1'b0);
        checks++;
        if (div_active !== 16'h00AB) begin
            errors++;
            $display("FAIL hi_commit got=%04h expected=00ab", div_active);
        end
        for (int i = 1; i <= 2 * 172 + 5; i++) begin
            step(1'b0, 1'b0, 2'h0, 8'h00, 1'b0);
            checks++;
            if (rx_tick !== exp_rx || tx_tick !== exp_tx) begin
                errors++;
                $display("FAIL shadow_model edge=%0d rx=%b tx=%b expected rx=%b tx=%b",
                         i, rx_tick, tx_tick, exp_rx, exp_tx);
            end
            if (rx_tick) rx_q.push_back(i);
        end
        checks++;
        if (rx_q.size() != 2 || rx_q[0] != 172 || rx_q[1] != 344) begin
            errors++;
            $display("FAIL period_172 count=%0d first=%0d expected ticks at 172 and 344",
                     rx_q.size(), (rx_q.size() == 0) ? -1 : rx_q[0]);
        end
        $display("test_shadow_write done");
    endtask

    task automatic test_zero_div();
        int tx_q[$];
        int rx_q[$];
        int bad;
        step(1'b0, 1'b1, 2'h2, 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'h3, 8'h00, 1'b0);
        bad = 0;
        for (int i = 1; i <= 3 * T_OVS; i++) begin
            step(1'b0, 1'b0, 2'h0, 8'h00, 1'b0);
            if (rx_tick !== 1'b1) bad++;
            if (tx_tick) tx_q.push_back(i);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL zero_div_rx low_cycles=%0d expected 0", bad);
        end
        checks++;
        if (tx_q.size() != 3 || tx_q[1] - tx_q[0] != T_OVS || tx_q[2] - tx_q[1] != T_OVS) begin
            errors++;
            $display("FAIL zero_div_tx count=%0d expected 3 pulses every %0d cycles", tx_q.size(), T_OVS);
        end
        step(1'b0, 1'b1, 2'h2, 8'h02, 1'b0);
        step(1'b0, 1'b1, 2'h3, 8'h00, 1'b0);
        if (rx_tick) rx_q.push_back(0);
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0, 2'h0, 8'h00, 1'b0);
            checks++;
            if (rx_tick !== exp_rx || tx_tick !== exp_tx) begin
                errors++;
                $display("FAIL div2_model edge=%0d rx=%b tx=%b expected rx=%b tx=%b",
                         i, rx_tick, tx_tick, exp_rx, exp_tx);
            end
            if (rx_tick) rx_q.push_back(i);
        end
        bad = 0;
        for (int k = 1; k < rx_q.size(); k++) if (rx_q[k] - rx_q[k-1] != 3) bad++;
        checks++;
        if (rx_q.size() != 5 || rx_q[0] != 0 || bad != 0) begin
            errors++;
            $display("FAIL div2_period count=%0d bad_gaps=%0d expected ticks at 0,3,6,9,12",
                     rx_q.size(), bad);
        end
        $display("test_zero_div done");
    endtask

    task automatic test_ignored_writes();
        int rx_q[$];
        step(1'b0, 1'b0, 2'h3, 8'h55, 1'b0);
        checks++;
        if (div_active !== 16'h0002) begin
            errors++;
            $display("FAIL wr0_hi got=%04h expected=0002", div_active);
        end
        step(1'b0, 1'b1, 2'h1, 8'h66, 1'b0);
        step(1'b0, 1'b1, 2'h0, 8'h77, 1'b0);
        checks++;
        if (div_active !== 16'h0002) begin
            errors++;
            $display("FAIL addr01_write got=%04h expected=0002", div_active);
        end
        step(1'b0, 1'b1, 2'h3, 8'h00, 1'b0);
        checks++;
        if (div_active !== 16'h0002) begin
            errors++;
            $display("FAIL shadow_held got=%04h expected=0002", div_active);
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0, 2'h0, 8'h00, 1'b0);
            if (rx_tick) rx_q.push_back(i);
        end
        checks++;
        if (rx_q.size() != 4 || rx_q[0] != 3 || rx_q[3] != 12) begin
            errors++;
            $display("FAIL ignored_period count=%0d first=%0d expected ticks at 3,6,9,12",
                     rx_q.size(), (rx_q.size() == 0) ? -1 : rx_q[0]);
        end
        $display("test_ignored_writes done");
    endtask

    task automatic test_reset_mid();
        int first_rx;
        step(1'b0, 1'b1, 2'h2, 8'h54, 1'b0);
        step(1'b0, 1'b1, 2'h3, 8'h00, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 2'h0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 2'h3, 8'h12, 1'b0);
        checks++;
        if (rx_tick !== 1'b0 || tx_tick !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ticks rx=%b tx=%b expected 0 0", rx_tick, tx_tick);
        end
        checks++;
        if (div_active !== 16'(T_DEF)) begin
            errors++;
            $display("FAIL midrst_div got=%04h expected=%04h", div_active, 16'(T_DEF));
        end
        first_rx = -1;
        for (int i = 1; i <= T_PER + 2; i++) begin
            step(1'b0, 1'b0, 2'h0, 8'h00, 1'b0);
            if (rx_tick && first_rx < 0) first_rx = i;
        end
        checks++;
        if (first_rx != T_PER) begin
            errors++;
            $display("FAIL midrst_first_rx edge=%0d expected=%0d", first_rx, T_PER);
        end
        step(1'b0, 1'b1, 2'h3, 8'h00, 1'b0);
        checks++;
        if (div_active !== 16'(T_DEF % 256)) begin
            errors++;
            $display("FAIL midrst_shadow got=%04h expected=%04h", div_active, 16'(T_DEF % 256));
        end
        $display("test_reset_mid done");
    endtask

`ifdef BAUD_TICK_RXSYNC_EN
    task automatic test_rxsync();
        int first_mid;
        int first_tx;
        step(1'b1, 1'b0, 2'h0, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 2'h0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 2'h0, 8'h00, 1'b1);
        checks++;
        if (rx_tick !== 1'b0 || tx_tick !== 1'b0 || rx_mid !== 1'b0) begin
            errors++;
            $display("FAIL sync_suppress rx=%b tx=%b mid=%b expected 0 0 0", rx_tick, tx_tick, rx_mid);
        end
        first_mid = -1;
        first_tx  = -1;
        for (int i = 1; i <= T_PER * T_OVS + 4; i++) begin
            step(1'b0, 1'b0, 2'h0, 8'h00, 1'b0);
            if (rx_mid && first_mid < 0) first_mid = i;
            if (tx_tick && first_tx < 0) first_tx = i;
        end
        checks++;
        if (first_mid != T_PER * T_OVS / 2) begin
            errors++;
            $display("FAIL sync_mid edge=%0d expected=%0d", first_mid, T_PER * T_OVS / 2);
        end
        checks++;
        if (first_tx != T_PER * T_OVS) begin
            errors++;
            $display("FAIL sync_tx edge=%0d expected=%0d", first_tx, T_PER * T_OVS);
        end
        $display("test_rxsync done");
    endtask
`endif

    task automatic test_random();
        logic       r, w, s;
        logic [1:0] a;
        logic [7:0] d;
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(299) == 0);
            w = ($urandom_range(3) == 0);
            a = 2'($urandom_range(3));
            d = (a == 2'h3) ? (($urandom_range(15) == 0) ? 8'h01 : 8'h00) : 8'($urandom_range(7));
`ifdef BAUD_TICK_RXSYNC_EN
            s = ($urandom_range(49) == 0);
`else
            s = 1'b0;
`endif
            step(r, w, a, d, s);
            checks++;
            if (rx_tick !== exp_rx || tx_tick !== exp_tx || div_active !== m_div) begin
                errors++;
                $display("FAIL random_model cycle=%0d rx=%b tx=%b div=%04h expected rx=%b tx=%b div=%04h",
                         i, rx_tick, tx_tick, div_active, exp_rx, exp_tx, m_div);
            end
`ifdef BAUD_TICK_RXSYNC_EN
            checks++;
            if (rx_mid !== exp_mid) begin
                errors++;
                $display("FAIL random_mid cycle=%0d got=%b expected=%b", i, rx_mid, exp_mid);
            end
`endif
        end
        verbose = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; ioaddr = 2'h0; divisor = 8'h00;
`ifdef BAUD_TICK_RXSYNC_EN
        rx_sync = 1'b0;
`endif
        test_reset();
        test_default_period();
        test_shadow_write();
        test_zero_div();
        test_ignored_writes();
        test_reset_mid();
`ifdef BAUD_TICK_RXSYNC_EN
        test_rxsync();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
